// File: rtl/sum_accumulator.sv
// sum_accumulator: registered, flow-controlled batch summer behind the 4-bit adder.
// Accepts count_p samples of the (width_p+1)-bit adder result over valid/ready and
// accumulates them. The batch total is then offered on a valid/ready output. When
// the total is taken, the accumulator clears and the next batch starts.
// Optional build macro: SUM_ACCUMULATOR_SATURATE_EN. When it is defined, the
// accumulator clamps to all ones on overflow instead of wrapping.
module sum_accumulator #(
    parameter int width_p     = 4,
    parameter int count_p     = 4,
    parameter int acc_width_p = 8
) (
    input  logic                   clk_i,
    input  logic                   reset_n_i,
    input  logic [width_p:0]       sum_i,
    input  logic                   valid_i,
    output logic                   ready_o,
    output logic [acc_width_p-1:0] total_o,
    output logic                   valid_o,
    input  logic                   ready_i,
    output logic                   overflow_o,
    output logic [7:0]             count_o
);

    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        DONE  = 1'b1
    } state_t;

    // Count value of the last sample in a batch, and the value held while DONE.
    localparam logic [7:0] last_cnt = 8'(count_p - 1);
    localparam logic [7:0] full_cnt = 8'(count_p);

    state_t                 state_reg, state_next;
    logic [acc_width_p-1:0] acc_reg, acc_next;
    logic [7:0]             cnt_reg, cnt_next;
    logic                   ovf_reg, ovf_next;

    // The sample is zero-extended by one extra bit so that the accumulator's
    // carry-out shows up in the top bit of the sum.
    logic [acc_width_p:0]   sum_ext;
    logic [acc_width_p:0]   add_full;
    logic                   add_carry;
    logic                   in_fire;
    logic                   out_fire;

    assign sum_ext   = {{(acc_width_p - width_p){1'b0}}, sum_i};
    assign add_full  = {1'b0, acc_reg} + sum_ext;
    assign add_carry = add_full[acc_width_p];

    // The handshake outputs are gated by reset. This keeps both sides idle while
    // reset_n_i is low, even before the first reset edge arrives.
    assign ready_o    = reset_n_i && (state_reg == ACCUM);
    assign valid_o    = reset_n_i && (state_reg == DONE);
    assign total_o    = acc_reg;
    assign count_o    = cnt_reg;
    assign overflow_o = ovf_reg;

    assign in_fire  = valid_i && ready_o;
    assign out_fire = valid_o && ready_i;

    // State register with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_reg <= ACCUM;
            acc_reg   <= '0;
            cnt_reg   <= '0;
            ovf_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            acc_reg   <= acc_next;
            cnt_reg   <= cnt_next;
            ovf_reg   <= ovf_next;
        end
    end

    // Next-state logic: accumulate in ACCUM, hold and then clear in DONE.
    always_comb begin
        state_next = state_reg;
        acc_next   = acc_reg;
        cnt_next   = cnt_reg;
        ovf_next   = ovf_reg;
        case (state_reg)
            ACCUM: begin
                if (in_fire) begin
`ifdef SUM_ACCUMULATOR_SATURATE_EN
                    // Clamp on carry. Once the accumulator is at all ones, every
                    // later nonzero sample carries again, so it stays clamped.
                    if (add_carry) begin
                        acc_next = '1;
                    end else begin
                        acc_next = add_full[acc_width_p-1:0];
                    end
`else
                    acc_next = add_full[acc_width_p-1:0];
`endif
                    ovf_next = ovf_reg | add_carry;
                    if (cnt_reg == last_cnt) begin
                        cnt_next   = full_cnt;
                        state_next = DONE;
                    end else begin
                        cnt_next = cnt_reg + 8'd1;
                    end
                end
            end
            DONE: begin
                // The input side stays closed until the total is taken. After
                // that, accepts resume on the following cycle.
                if (out_fire) begin
                    acc_next   = '0;
                    cnt_next   = '0;
                    ovf_next   = 1'b0;
                    state_next = ACCUM;
                end
            end
            default: begin
                state_next = ACCUM;
            end
        endcase
    end

endmodule

// File: tb/tb_sum_accumulator.sv
// Directed self-checking bench for sum_accumulator.
// It uses three instances: the default configuration, a 6-bit accumulator for the
// overflow and saturation cases, and count_p=1 for the single-sample batch.
// Expected values for the 6-bit case follow SUM_ACCUMULATOR_SATURATE_EN.
`timescale 1ns/1ps
module tb_sum_accumulator;

    logic clk = 1'b0;
    logic reset_n;

    // Instance A: defaults (width 4, count 4, acc 8)
    logic [4:0] a_sum;
    logic       a_valid, a_ready, a_vout, a_rdy_in, a_ovf;
    logic [7:0] a_total, a_count;

    // Instance B: acc_width_p = 6
    logic [4:0] b_sum;
    logic       b_valid, b_ready, b_vout, b_rdy_in, b_ovf;
    logic [5:0] b_total;
    logic [7:0] b_count;

    // Instance C: count_p = 1
    logic [4:0] c_sum;
    logic       c_valid, c_ready, c_vout, c_rdy_in, c_ovf;
    logic [7:0] c_total, c_count;

    int assert_count = 0;
    int fail_count   = 0;

    always #5 clk = ~clk;

    sum_accumulator #(.width_p(4), .count_p(4), .acc_width_p(8)) dut_a (
        .clk_i(clk), .reset_n_i(reset_n), .sum_i(a_sum), .valid_i(a_valid),
        .ready_o(a_ready), .total_o(a_total), .valid_o(a_vout), .ready_i(a_rdy_in),
        .overflow_o(a_ovf), .count_o(a_count)
    );

    sum_accumulator #(.width_p(4), .count_p(4), .acc_width_p(6)) dut_b (
        .clk_i(clk), .reset_n_i(reset_n), .sum_i(b_sum), .valid_i(b_valid),
        .ready_o(b_ready), .total_o(b_total), .valid_o(b_vout), .ready_i(b_rdy_in),
        .overflow_o(b_ovf), .count_o(b_count)
    );

    sum_accumulator #(.width_p(4), .count_p(1), .acc_width_p(8)) dut_c (
        .clk_i(clk), .reset_n_i(reset_n), .sum_i(c_sum), .valid_i(c_valid),
        .ready_o(c_ready), .total_o(c_total), .valid_o(c_vout), .ready_i(c_rdy_in),
        .overflow_o(c_ovf), .count_o(c_count)
    );

    // Compares one observed value against its expected value.
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assert_count++;
        if (obs !== exp) begin
            fail_count++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advances one clock. Inputs change and outputs are sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offers one sample to instance A for exactly one edge.
    task automatic send_a(input logic [4:0] s);
        a_sum   = s;
        a_valid = 1'b1;
        tick();
        a_valid = 1'b0;
        $display("A send %0d -> count %0d total %0d", s, a_count, a_total);
    endtask

    task automatic send_b(input logic [4:0] s);
        b_sum   = s;
        b_valid = 1'b1;
        tick();
        b_valid = 1'b0;
        $display("B send %0d -> count %0d total %0d", s, b_count, b_total);
    endtask

    logic [5:0] b_exp_total;

    initial begin
        reset_n = 1'b0;
        a_sum = '0; a_valid = 1'b0; a_rdy_in = 1'b0;
        b_sum = '0; b_valid = 1'b0; b_rdy_in = 1'b0;
        c_sum = '0; c_valid = 1'b0; c_rdy_in = 1'b0;

        // Reset: ready must stay low while reset_n is low.
        tick();
        tick();
        check("ready_in_reset", a_ready, 1'b0);
        check("valid_in_reset", a_vout, 1'b0);
        reset_n = 1'b1;
        tick();
        check("rst_ready", a_ready, 1'b1);
        check("rst_valid", a_vout, 1'b0);
        check("rst_count", a_count, 8'd0);
        check("rst_total", a_total, 8'd0);
        check("rst_ovf", a_ovf, 1'b0);

        // Back-to-back batch: 3 + 7 + 16 + 31 = 57.
        a_sum = 5'd3;  a_valid = 1'b1; tick();
        a_sum = 5'd7;  tick();
        a_sum = 5'd16; tick();
        check("cnt_before_last", a_count, 8'd3);
        check("valid_before_last", a_vout, 1'b0);
        a_sum = 5'd31; tick();
        $display("A batch 3,7,16,31 -> valid %0d total %0d", a_vout, a_total);
        check("batch_valid", a_vout, 1'b1);
        check("batch_total", a_total, 8'd57);
        check("batch_ovf", a_ovf, 1'b0);
        check("batch_ready", a_ready, 1'b0);
        check("batch_count", a_count, 8'd4);

        // Backpressure: keep offering 9 for 5 cycles. Nothing may be accepted.
        a_sum = 5'd9; a_valid = 1'b1; a_rdy_in = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold_total", a_total, 8'd57);
            check("hold_count", a_count, 8'd4);
            check("hold_valid", a_vout, 1'b1);
        end
        a_valid = 1'b0;
        a_rdy_in = 1'b1;
        tick();
        a_rdy_in = 1'b0;
        $display("A drain -> ready %0d count %0d total %0d", a_ready, a_count, a_total);
        check("drain_ready", a_ready, 1'b1);
        check("drain_count", a_count, 8'd0);
        check("drain_total", a_total, 8'd0);
        check("drain_valid", a_vout, 1'b0);
        check("drain_ovf", a_ovf, 1'b0);

        // Overflow in a 6-bit accumulator: 31 x 4.
        for (int i = 0; i < 4; i++) send_b(5'd31);
`ifdef SUM_ACCUMULATOR_SATURATE_EN
        b_exp_total = 6'd63;
`else
        b_exp_total = 6'd60;
`endif
        check("acc6_valid", b_vout, 1'b1);
        check("acc6_total", b_total, b_exp_total);
        check("acc6_ovf", b_ovf, 1'b1);
        b_rdy_in = 1'b1;
        tick();
        b_rdy_in = 1'b0;
        check("acc6_ovf_cleared", b_ovf, 1'b0);
        check("acc6_total_cleared", b_total, 6'd0);

        // Reset mid-batch discards the partial sum.
        send_a(5'd10);
        send_a(5'd12);
        check("partial_total", a_total, 8'd22);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        check("midrst_count", a_count, 8'd0);
        check("midrst_total", a_total, 8'd0);
        for (int i = 0; i < 4; i++) send_a(5'd1);
        check("after_rst_total", a_total, 8'd4);
        check("after_rst_ovf", a_ovf, 1'b0);
        check("after_rst_valid", a_vout, 1'b1);

        // count_p = 1 with sum held: valid pulses every other cycle.
        c_sum = 5'd20; c_valid = 1'b1; c_rdy_in = 1'b1;
        check("c1_ready0", c_ready, 1'b1);
        for (int i = 0; i < 4; i++) begin
            tick();
            $display("C cycle %0d -> ready %0d valid %0d total %0d", i, c_ready, c_vout, c_total);
            check("c1_ready", c_ready, (i % 2 == 0) ? 1'b0 : 1'b1);
            check("c1_valid", c_vout, (i % 2 == 0) ? 1'b1 : 1'b0);
            check("c1_total", c_total, (i % 2 == 0) ? 32'd20 : 32'd0);
        end
        c_valid = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule

// File: doc/sum_accumulator.md
Name: sum_accumulator

Overview:
- Downstream consumer of the 4-bit `adder` stage.
- Accepts the adder's (width_p+1)-bit sum (carry-out in the MSB) over a valid/ready handshake and accumulates count_p consecutive samples.
- Presents the total on an output valid/ready handshake, then clears and starts the next batch.
- Gives the lab datapath a registered, flow-controlled multi-operand sum stage behind the combinational adder.

Parameters:
- width_p, 4, adder operand width; sum_i is width_p+1 bits.
- count_p, 4, samples per batch; legal range 1..255.
- acc_width_p, 8, accumulator/total width; must be >= width_p+1.

Ports:
- clk_i  input  1  rising-edge clock.
- reset_n_i  input  1  synchronous, active-low reset.
- sum_i  input  width_p+1  adder result, {carry, sum}.
- valid_i  input  1  sum_i valid.
- ready_o  output  1  stage can accept sum_i.
- total_o  output  acc_width_p  batch total.
- valid_o  output  1  total_o valid.
- ready_i  input  1  downstream accepts total_o.
- overflow_o  output  1  sticky; batch total exceeded acc_width_p bits.
- count_o  output  8  samples accepted in the current batch.

Behaviour:
- One clock; reset is synchronous and active-low. clk_i and reset_n_i sample on the rising edge of clk_i; the reset takes effect only at a clock edge while reset_n_i=0.
- Reset values:
  - state=ACCUM; acc=0; cnt=0; overflow_o=0; valid_o=0.
  - ready_o=0 while reset_n_i=0.
  - total_o=0; count_o=0.
- States:
  - ACCUM: ready_o=1, valid_o=0.
  - DONE: ready_o=0, valid_o=1.
- Input handshake (ACCUM) fires when valid_i & ready_o:
  - acc <= acc + zero-extended sum_i, truncated to acc_width_p.
  - overflow_o <= overflow_o | carry out of bit acc_width_p-1.
  - cnt <= cnt+1.
- If the fire occurs with cnt==count_p-1: state <= DONE and cnt is held at count_p. The total is visible on total_o with valid_o=1 on the next cycle (1-cycle latency from the last accepted sample).
- With valid_i=0 in ACCUM, all state is held; no timeout.
- In DONE:
  - total_o, overflow_o and count_o are held stable until ready_i=1.
  - sum_i/valid_i are ignored; no input is accepted.
- Output handshake (DONE & ready_i) in that cycle:
  - Registers update: acc<=0, cnt<=0, overflow_o<=0, state<=ACCUM.
  - The next input can be accepted the following cycle; no same-cycle accept/drain bypass.
- total_o = acc at all times. It is meaningful only when valid_o=1.
- count_o = cnt.
- count_p=1: every accepted sample goes directly to DONE; the total equals that sample.
- Reset asserted mid-batch or in DONE discards the partial or unconsumed total. There is no output glitch beyond the valid_o/ready_o deassertion while reset_n_i=0.
- valid_i may be held high across multiple cycles. Each cycle with valid_i & ready_o counts as a distinct sample, so upstream must present a new sum each accepted cycle.

Optional Feature:
- Macro SUM_ACCUMULATOR_SATURATE_EN.
- Defined: on a carry out of the accumulator, acc is clamped to all ones (2^acc_width_p - 1) and held there for the rest of the batch. overflow_o is still set.
- Undefined (default): acc wraps modulo 2^acc_width_p; overflow_o is set.

Test Plan:
- Reset, then release with valid_i=0 -> ready_o=1, valid_o=0, count_o=0, total_o=0, overflow_o=0.
- Defaults (width_p=4, count_p=4, acc_width_p=8); send sums 5'd3, 5'd7, 5'd16, 5'd31 back-to-back -> valid_o=1 one cycle after the 4th accept, total_o=8'd57, overflow_o=0, ready_o=0.
- With total pending, hold ready_i=0 for 5 cycles while driving valid_i=1, sum_i=5'd9 -> total_o stays 57, count_o stays 4, no input accepted. Pulse ready_i=1 -> next cycle ready_o=1, count_o=0, total_o=0.
- acc_width_p=6; send 31,31,31,31:
  - Macro undefined -> total_o=6'd60, overflow_o=1.
  - Macro defined -> total_o=6'd63, overflow_o=1.
- Send 2 samples (10, 12); assert reset_n_i=0 for one edge; then send 1,1,1,1 -> total_o=4, overflow_o=0.
- count_p=1; send 5'd20 with ready_i tied 1 -> valid_o pulses every other cycle with total_o=20. ready_o toggles 1,0,1,0.
